rv_decode_issue: RTL and testbench
==================================

Name: rv_decode_issue

Overview:
- Decode/operand-issue stage directly upstream of the integer ALU.
- Accepts 32-bit RV32I OP and OP-IMM instructions from fetch and reads the 32x32 register file.
- Tracks in-flight destination registers with a scoreboard and stalls on read-after-write hazards.
- Issues a registered operand bundle (i_en, funct3, funct7, rs1, rs2, rd address) to the ALU via a valid/ready handshake; accepts writebacks from the downstream writeback stage.

Parameters:
- RESET_REGFILE, 1: 1 = register file cleared by reset; 0 = register file not reset (x0 still reads 0).
- SB_WIDTH, 32: scoreboard entries, one per architectural register; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  ALU/execute consumes the bundle.
- out_i_en  out  1  1 = immediate form (OP-IMM), 0 = register form (OP).
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25] for OP; 0 for OP-IMM.
- out_rs1  out  32  rs1 operand value.
- out_rs2  out  32  rs2 value (OP) or sign-extended I-immediate (OP-IMM).
- out_rd  out  5  destination register index, returned later on wb_addr.
- wb_en  in  1  writeback strobe.
- wb_addr  in  5  writeback register index.
- wb_data  in  32  writeback value.
- illegal  out  1  one-cycle pulse: an unsupported instruction was consumed.

Behaviour:
- Reset values: out_valid=0; all out_* data=0; illegal=0; scoreboard all clear; regfile all 0 when RESET_REGFILE=1. Reset mid-operation discards the held bundle and all in-flight state.
- Decode: opcode 0110011 -> OP (i_en=0). Opcode 0010011 -> OP-IMM (i_en=1, rs2 = {{20{instr[31]}}, instr[31:20]}). For shifts, the full 12-bit immediate is passed unmodified so bits [11:5] still select logical vs arithmetic shift. Any other opcode -> illegal.
- Hazard: asserted when busy[rs1], or (OP and busy[rs2]). Index 0 is never busy. OP-IMM ignores rs2.
- in_ready = (!out_valid || out_ready) && !hazard. Illegal instructions are not subject to hazard stalls.
- Accept (in_valid && in_ready), legal: on the next edge the output register loads the bundle, out_valid=1, and busy[rd] is set if rd != 0. Regfile reads are combinational at accept.
- Accept, illegal: the instruction is dropped, illegal pulses the next cycle, out_valid follows the normal drain rule, and the scoreboard is unchanged.
- Drain: out_valid && out_ready with no accept clears out_valid next edge.
- Stall: the bundle holds stable while out_valid && !out_ready.
- Writeback: wb_en && wb_addr != 0 writes the regfile and clears busy[wb_addr] on the edge. Writes to x0 are ignored.
- Same-edge set and clear of the same index: set wins, because the new writer takes ownership.
- Latency: one cycle from accept to out_valid when there is no hazard. Throughput: one instruction per cycle.
- Reads of x0 always return 0.

Optional Feature:
- Macro: RV_DECODE_BYPASS_EN.
- Defined: a wb_en to a register being read in the same cycle forwards wb_data into the operand. The busy bit for that register is treated as clear for the same-cycle hazard check, so a dependent instruction issues in the writeback cycle.
- Undefined: the hazard check uses registered busy bits only. A dependent instruction issues one cycle after writeback and reads the updated regfile.

Decomposition:
- Package rv_pkg holds:
  - opcode constants OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011;
  - a typedef struct issue_bundle_t {i_en, funct3, funct7, rs1, rs2, rd};
  - a typedef reg_idx_t (5 bits).
- One natural sub-module: rv_regfile (2 async read ports, 1 sync write port, x0 hardwired, optional reset). Decode, scoreboard and the output register stay in rv_decode_issue.

Test Plan:
- Reset, then issue ADDI x1,x0,5 (0x00500093) -> next cycle out_valid=1, i_en=1, funct3=0, rs1=0, rs2=5, rd=1; busy[1]=1.
- Back-to-back ADDI x1 then ADD x2,x1,x1 with no writeback -> in_ready=0 until wb_en,wb_addr=1,wb_data=5. With bypass: issue in the wb cycle, rs1=rs2=5. Without bypass: issue one cycle later, same values.
- SRAI x3,x4,3 (0x40325193) -> out_rs2=0x00000403, funct7=0, i_en=1.
- Hold out_ready=0 for 4 cycles with the bundle pending -> bundle stable, in_ready=0. Release -> the next instruction is accepted the same cycle.
- LW opcode 0000011 presented -> illegal pulses once, out_valid unchanged, scoreboard unchanged.
- Assert rst while busy[5]=1 and out_valid=1 -> out_valid=0 and scoreboard clear. ADD x6,x5,x5 is then accepted immediately and reads rs1=rs2=0 when RESET_REGFILE=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I decode/issue stage.
package rv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef logic [4:0] reg_idx_t;

   typedef struct packed {
      logic        i_en;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] rs1;
      logic [31:0] rs2;
      reg_idx_t    rd;
   } issue_bundle_t;

   // Sign-extended I-type immediate; shift encodings keep bits [11:5] intact.
   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 is hardwired to zero; RESET_REGFILE selects whether reset clears the array.
module rv_regfile
   import rv_pkg::*;
#(
   parameter bit RESET_REGFILE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  reg_idx_t    raddr1,
   input  reg_idx_t    raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  reg_idx_t    waddr,
   input  logic [31:0] wdata
);

   logic [31:0] mem [32];
   logic        wr_en;

   assign wr_en = we && (waddr != '0);

   generate
      if (RESET_REGFILE) begin : g_rst
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < 32; i++) begin
                  mem[i] <= '0;
               end
            end else if (wr_en) begin
               mem[waddr] <= wdata;
            end
         end
      end else begin : g_norst
         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[waddr] <= wdata;
            end
         end
      end
   endgenerate

   assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/rv_decode_issue.sv
// RV32I OP/OP-IMM decode and operand issue with RAW scoreboard stalls.
// Define RV_DECODE_BYPASS_EN to forward same-cycle writebacks into operands.
module rv_decode_issue
   import rv_pkg::*;
#(
   parameter bit RESET_REGFILE = 1'b1,
   parameter int SB_WIDTH      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_i_en,
   output logic [2:0]  out_funct3,
   output logic [6:0]  out_funct7,
   output logic [31:0] out_rs1,
   output logic [31:0] out_rs2,
   output logic [4:0]  out_rd,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        illegal
);

   logic [6:0]          opcode;
   reg_idx_t            rs1_idx;
   reg_idx_t            rs2_idx;
   reg_idx_t            rd_idx;
   logic                is_op;
   logic                is_op_imm;
   logic                legal;
   logic [31:0]         rf_rdata1;
   logic [31:0]         rf_rdata2;
   logic [31:0]         rs1_val;
   logic [31:0]         rs2_val;
   logic [SB_WIDTH-1:0] busy_reg;
   logic [SB_WIDTH-1:0] busy_next;
   logic [SB_WIDTH-1:0] busy_eff;
   logic [SB_WIDTH-1:0] set_vec;
   logic [SB_WIDTH-1:0] clr_vec;
   logic                hazard;
   logic                accept;
   logic                issue;
   issue_bundle_t       bundle_reg;
   issue_bundle_t       bundle_next;
   logic                out_valid_reg;
   logic                illegal_reg;

   assign opcode    = in_instr[6:0];
   assign rd_idx    = in_instr[11:7];
   assign rs1_idx   = in_instr[19:15];
   assign rs2_idx   = in_instr[24:20];
   assign is_op     = (opcode == OPC_OP);
   assign is_op_imm = (opcode == OPC_OP_IMM);
   assign legal     = is_op || is_op_imm;

   rv_regfile #(
      .RESET_REGFILE (RESET_REGFILE)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1_idx),
      .raddr2 (rs2_idx),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data)
   );

   // Per-entry set (new writer issued) and clear (writeback) strobes; x0 never tracked.
   genvar gi;
   generate
      for (gi = 0; gi < SB_WIDTH; gi++) begin : g_sb
         if (gi == 0) begin : g_x0
            assign set_vec[gi] = 1'b0;
            assign clr_vec[gi] = 1'b0;
         end else begin : g_xn
            assign set_vec[gi] = issue && (rd_idx == reg_idx_t'(gi));
            assign clr_vec[gi] = wb_en && (wb_addr == reg_idx_t'(gi));
         end
      end
   endgenerate

`ifdef RV_DECODE_BYPASS_EN
   assign busy_eff = busy_reg & ~clr_vec;
   assign rs1_val  = (wb_en && (wb_addr == rs1_idx) && (rs1_idx != '0)) ? wb_data : rf_rdata1;
   assign rs2_val  = (wb_en && (wb_addr == rs2_idx) && (rs2_idx != '0)) ? wb_data : rf_rdata2;
`else
   assign busy_eff = busy_reg;
   assign rs1_val  = rf_rdata1;
   assign rs2_val  = rf_rdata2;
`endif

   // Illegal opcodes have no operands, so they never stall.
   assign hazard   = legal && (busy_eff[rs1_idx] || (is_op && busy_eff[rs2_idx]));
   assign in_ready = (!out_valid_reg || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;
   assign issue    = accept && legal;

   always_comb begin
      bundle_next        = '0;
      bundle_next.i_en   = is_op_imm;
      bundle_next.funct3 = in_instr[14:12];
      bundle_next.funct7 = is_op ? in_instr[31:25] : 7'd0;
      bundle_next.rs1    = rs1_val;
      bundle_next.rs2    = is_op_imm ? imm_i(in_instr) : rs2_val;
      bundle_next.rd     = rd_idx;
   end

   // Set after clear so a same-edge issue to the writeback index keeps ownership.
   assign busy_next = (busy_reg & ~clr_vec) | set_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         bundle_reg    <= '0;
         illegal_reg   <= 1'b0;
         busy_reg      <= '0;
      end else begin
         if (issue) begin
            out_valid_reg <= 1'b1;
            bundle_reg    <= bundle_next;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
         illegal_reg <= accept && !legal;
         busy_reg    <= busy_next;
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_i_en   = bundle_reg.i_en;
   assign out_funct3 = bundle_reg.funct3;
   assign out_funct7 = bundle_reg.funct7;
   assign out_rs1    = bundle_reg.rs1;
   assign out_rs2    = bundle_reg.rs2;
   assign out_rd     = bundle_reg.rd;
   assign illegal    = illegal_reg;

endmodule

// File: tb/tb_rv_decode_issue.sv
// Self-checking bench for rv_decode_issue: directed scenarios plus randomized
// traffic checked every cycle against an array/queue model of the stage.
module tb_rv_decode_issue;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_i_en;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [31:0] out_rs1;
   logic [31:0] out_rs2;
   logic [4:0]  out_rd;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        illegal;

   rv_decode_issue #(
      .RESET_REGFILE (1'b1),
      .SB_WIDTH      (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_i_en   (out_i_en),
      .out_funct3 (out_funct3),
      .out_funct7 (out_funct7),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_rd     (out_rd),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

`ifdef RV_DECODE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   bit          m_valid;
   bit          m_illegal;
   bit          m_i_en;
   logic [2:0]  m_funct3;
   logic [6:0]  m_funct7;
   logic [31:0] m_rs1;
   logic [31:0] m_rs2;
   logic [4:0]  m_rd;
   bit          m_busy [32];
   logic [31:0] m_rf [32];
   logic [4:0]  pending [$];
   bit          last_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_illegal = 0; m_i_en = 0;
      m_funct3 = '0; m_funct7 = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      for (int i = 0; i < 32; i++) begin
         m_busy[i] = 0;
         m_rf[i]   = '0;
      end
      pending.delete();
   endtask

   function automatic bit busy_now(input logic [4:0] idx);
      if (idx == 0) return 0;
      if (BYPASS && wb_en && wb_addr == idx) return 0;
      return m_busy[idx];
   endfunction

   function automatic logic [31:0] read_reg(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if (BYPASS && wb_en && wb_addr == idx) return wb_data;
      return m_rf[idx];
   endfunction

   function automatic bit model_ready();
      logic [6:0] opc = in_instr[6:0];
      bit legal = (opc == OPC_OP) || (opc == OPC_OP_IMM);
      bit stall = legal && (busy_now(in_instr[19:15]) ||
                            (opc == OPC_OP && busy_now(in_instr[24:20])));
      return (!m_valid || out_ready) && !stall;
   endfunction

   task automatic model_edge();
      logic [6:0] opc = in_instr[6:0];
      bit legal = (opc == OPC_OP) || (opc == OPC_OP_IMM);
      bit acc = in_valid && model_ready();
      logic [4:0] rd = in_instr[11:7];
      if (m_valid && out_ready) pending.push_back(m_rd);
      if (acc && legal) begin
         m_valid  = 1;
         m_i_en   = (opc == OPC_OP_IMM);
         m_funct3 = in_instr[14:12];
         m_funct7 = (opc == OPC_OP) ? in_instr[31:25] : 7'd0;
         m_rs1    = read_reg(in_instr[19:15]);
         if (opc == OPC_OP_IMM) begin
            m_rs2 = 32'(signed'(in_instr[31:20]));
         end else begin
            m_rs2 = read_reg(in_instr[24:20]);
         end
         m_rd = rd;
         $display("issue  instr=%h rd=x%0d rs1=%h rs2=%h t=%0t", in_instr, rd, m_rs1, m_rs2, $time);
      end else if (out_ready) begin
         m_valid = 0;
      end
      m_illegal = acc && !legal;
      if (m_illegal) $display("drop   instr=%h (illegal opcode) t=%0t", in_instr, $time);
      if (wb_en && wb_addr != 0) begin
         m_rf[wb_addr]   = wb_data;
         m_busy[wb_addr] = 0;
      end
      if (acc && legal && rd != 0) m_busy[rd] = 1;
   endtask

   task automatic compare_outputs();
      check("out_valid", out_valid, m_valid);
      check("illegal", illegal, m_illegal);
      check("out_i_en", out_i_en, m_i_en);
      check("out_funct3", out_funct3, m_funct3);
      check("out_funct7", out_funct7, m_funct7);
      check("out_rs1", out_rs1, m_rs1);
      check("out_rs2", out_rs2, m_rs2);
      check("out_rd", out_rd, m_rd);
   endtask

   task automatic step(input bit v, input logic [31:0] ins, input bit ordy,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
      @(negedge clk);
      in_valid = v; in_instr = ins; out_ready = ordy;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      last_ready = in_ready;
      check("in_ready", in_ready, model_ready());
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 0; out_ready = 0; wb_en = 0;
      #1;
      model_reset();
      compare_outputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int s = $urandom_range(0, 19);
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      if (s < 9)       w[6:0] = OPC_OP;
      else if (s < 18) w[6:0] = OPC_OP_IMM;
      else if (s < 19) w[6:0] = 7'b0000011;
      else             w[6:0] = 7'b1100011;
      return w;
   endfunction

   initial begin
      model_reset();
      do_reset();
      check("reset out_valid", out_valid, 32'd0);
      check("reset out_rs2", out_rs2, 32'd0);

      // ADDI x1,x0,5
      step(1, 32'h00500093, 1, 0, 0, 0);
      check("addi valid", out_valid, 32'd1);
      check("addi i_en", out_i_en, 32'd1);
      check("addi rs1", out_rs1, 32'd0);
      check("addi rs2", out_rs2, 32'd5);
      check("addi rd", out_rd, 32'd1);

      // ADD x2,x1,x1 stalls on busy x1 until writeback
      step(1, 32'h00108133, 1, 0, 0, 0);
      check("add raw stall", last_ready, 32'd0);
      step(1, 32'h00108133, 1, 1, 5'd1, 32'd5);
      check("add wb-cycle ready", last_ready, BYPASS ? 32'd1 : 32'd0);
      if (!BYPASS) begin
         step(1, 32'h00108133, 1, 0, 0, 0);
         check("add post-wb ready", last_ready, 32'd1);
      end
      check("add rs1", out_rs1, 32'd5);
      check("add rs2", out_rs2, 32'd5);
      check("add rd", out_rd, 32'd2);

      // SRAI x3,x4,3 keeps funct7 bits inside the immediate
      step(1, 32'h40325193, 1, 0, 0, 0);
      check("srai rs2", out_rs2, 32'h00000403);
      check("srai funct7", out_funct7, 32'd0);
      check("srai i_en", out_i_en, 32'd1);

      // Back-pressure: hold for 4 cycles, then release accepts same cycle
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h000003B3, 0, 0, 0, 0);
         check("stall ready", last_ready, 32'd0);
         check("stall rd hold", out_rd, 32'd3);
      end
      step(1, 32'h000003B3, 1, 0, 0, 0);
      check("release ready", last_ready, 32'd1);
      check("release rd", out_rd, 32'd7);

      // Drain, then LW is dropped as illegal
      step(0, 32'h0, 1, 0, 0, 0);
      step(1, 32'h0000A283, 1, 0, 0, 0);
      check("lw illegal", illegal, 32'd1);
      check("lw out_valid", out_valid, 32'd0);
      step(0, 32'h0, 1, 0, 0, 0);
      check("lw pulse end", illegal, 32'd0);

      // Reset with busy x5 and a pending bundle
      step(1, 32'h00700293, 0, 0, 0, 0);
      check("addi x5 valid", out_valid, 32'd1);
      do_reset();
      check("mid reset out_valid", out_valid, 32'd0);
      step(1, 32'h00528333, 1, 0, 0, 0);
      check("add x6 ready", last_ready, 32'd1);
      check("add x6 rs1", out_rs1, 32'd0);
      check("add x6 rs2", out_rs2, 32'd0);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         bit          we = 0;
         logic [4:0]  wa = '0;
         logic [31:0] wd = '0;
         if (pending.size() > 0 && $urandom_range(0, 2) != 0) begin
            we = 1;
            wa = pending.pop_front();
            wd = $urandom;
         end
         step(($urandom_range(0, 4) != 0), rand_instr(), ($urandom_range(0, 9) < 7), we, wa, wd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
